// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the FIB hash table.
//   - FIB_* localparams: default geometry; the packed entry struct is sized by
//     these, so a different geometry is configured here rather than per instance.
//   - OP_* constants: request opcode encoding.
//   - fib_state_e: controller states.
//   - fib_entry_t: one table entry {valid, prefix, len, faces}.
//   - fib_mask_prefix(): zeroes every prefix bit below the prefix length.
package fib_pkg;

    localparam int FIB_PREFIX_W = 64;
    localparam int FIB_LEN_W    = 7;
    localparam int FIB_DEPTH    = 1024;
    localparam int FIB_IDX_W    = 10;
    localparam int FIB_FACES    = 8;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HREQ   = 3'd1,
        ST_HWAIT  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } fib_state_e;

    typedef struct packed {
        logic                    valid;
        logic [FIB_PREFIX_W-1:0] prefix;
        logic [FIB_LEN_W-1:0]    len;
        logic [FIB_FACES-1:0]    faces;
    } fib_entry_t;

    // Keeps the top len bits of an MSB-aligned prefix. Shifting all-ones right
    // by len leaves ones exactly on the don't-care bits; len==0 masks everything
    // (default route) and len>=width keeps everything.
    function automatic logic [FIB_PREFIX_W-1:0] fib_mask_prefix(
        input logic [FIB_PREFIX_W-1:0] prefix,
        input logic [FIB_LEN_W-1:0]    len
    );
        return prefix & ~({FIB_PREFIX_W{1'b1}} >> len);
    endfunction

endpackage

// File: rtl/fib_entry_ram.sv
// fib_entry_ram: DEPTH x fib_entry_t register array.
//   clk    - rising-edge clock
//   clr    - synchronous clear of every valid bit (driven by the block reset)
//   we     - write enable, waddr/wdata written on the rising edge
//   raddr  - combinational read address, rdata the entry stored there
module fib_entry_ram
    import fib_pkg::*;
#(
    parameter int DEPTH = FIB_DEPTH,
    parameter int IDX_W = FIB_IDX_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  fib_entry_t       wdata,
    input  logic [IDX_W-1:0] raddr,
    output fib_entry_t       rdata
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    fib_entry_t       mem_q [DEPTH];

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[waddr] = wdata.valid;
        end
    end

    // NOTE: only the valid bits are reset; the payload array is never read
    // without its valid bit, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // The separately reset valid vector is authoritative over the stored copy.
    always_comb begin
        rdata       = mem_q[raddr];
        rdata.valid = valid_q[raddr];
    end

endmodule

// File: rtl/fib_hash_table.sv
// fib_hash_table: hash-indexed FIB serving lookup/insert/delete one at a time.
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake (ready only in IDLE)
//   req_op/prefix/len/faces   - opcode, MSB-aligned prefix, length, face bitmap
//   hash_req                  - one-cycle pulse asking the hash unit for an index
//   hash_prefix_in/len_in     - masked prefix and length presented to the hash unit
//   hash_valid/hash           - hash result (accepted only while waiting for it)
//   rsp_valid/rsp_ready       - response handshake, fields held until accepted
//   rsp_hit/reject/faces      - outcome; faces nonzero only on a lookup hit
// Optional: define FIB_STATS_EN to add saturating 16-bit counters
//   stat_hits, stat_misses (lookups) and stat_rejects (any op).
module fib_hash_table
    import fib_pkg::*;
#(
    parameter int PREFIX_W = FIB_PREFIX_W,
    parameter int LEN_W    = FIB_LEN_W,
    parameter int DEPTH    = FIB_DEPTH,
    parameter int IDX_W    = FIB_IDX_W,
    parameter int FACES    = FIB_FACES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [PREFIX_W-1:0] req_prefix,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [FACES-1:0]    req_faces,
    output logic                hash_req,
    output logic [PREFIX_W-1:0] hash_prefix_in,
    output logic [LEN_W-1:0]    hash_len_in,
    input  logic                hash_valid,
    input  logic [IDX_W-1:0]    hash,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic                rsp_reject,
    output logic [FACES-1:0]    rsp_faces
`ifdef FIB_STATS_EN
    ,
    output logic [15:0]         stat_hits,
    output logic [15:0]         stat_misses,
    output logic [15:0]         stat_rejects
`endif
);

    fib_state_e          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [FACES-1:0]    faces_q, faces_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                hit_q, hit_d;
    logic                reject_q, reject_d;
    logic [FACES-1:0]    rfaces_q, rfaces_d;

    logic                ram_we;
    fib_entry_t          ram_wdata;
    fib_entry_t          ram_rdata;
    logic                match;

    fib_entry_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .clr   (rst),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (ram_wdata),
        .raddr (idx_q),
        .rdata (ram_rdata)
    );

    // prefix_q is stored already masked, so a plain equality is the prefix match.
    assign match = ram_rdata.valid && (ram_rdata.len == len_q) && (ram_rdata.prefix == prefix_q);

    always_comb begin
        // NOTE: every signal gets its hold/default value first, so no branch
        // can leave one unassigned and infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        len_d     = len_q;
        faces_d   = faces_q;
        prefix_d  = prefix_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        reject_d  = reject_q;
        rfaces_d  = rfaces_q;
        ram_we    = 1'b0;
        ram_wdata = ram_rdata;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    len_d    = req_len;
                    faces_d  = req_faces;
                    prefix_d = fib_mask_prefix(req_prefix, req_len);
                    if ((req_len > LEN_W'(PREFIX_W)) || (req_op == OP_RSVD)) begin
                        hit_d    = 1'b0;
                        reject_d = 1'b1;
                        rfaces_d = '0;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_HREQ;
                    end
                end
            end
            ST_HREQ: begin
                state_d = ST_HWAIT;
            end
            ST_HWAIT: begin
                if (hash_valid) begin
                    idx_d   = hash;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d  = ST_RESP;
                hit_d    = 1'b0;
                reject_d = 1'b0;
                rfaces_d = '0;
                if (op_q == OP_LOOKUP) begin
                    hit_d    = match;
                    rfaces_d = match ? ram_rdata.faces : '0;
                end else if ((op_q == OP_DELETE) || (faces_q == '0)) begin
                    // An insert with an empty face set withdraws the route.
                    if (match) begin
                        ram_we          = 1'b1;
                        ram_wdata.valid = 1'b0;
                        hit_d           = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (!ram_rdata.valid || match) begin
                    ram_we           = 1'b1;
                    ram_wdata.valid  = 1'b1;
                    ram_wdata.prefix = prefix_q;
                    ram_wdata.len    = len_q;
                    ram_wdata.faces  = faces_q;
                    hit_d            = 1'b1;
                end else begin
                    // Bucket owned by a different prefix: no chaining, refuse.
                    reject_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d  = ST_IDLE;
                    hit_d    = 1'b0;
                    reject_d = 1'b0;
                    rfaces_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOOKUP;
            len_q    <= '0;
            faces_q  <= '0;
            prefix_q <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            reject_q <= 1'b0;
            rfaces_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            faces_q  <= faces_d;
            prefix_q <= prefix_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            reject_q <= reject_d;
            rfaces_q <= rfaces_d;
        end
    end

    // req_ready is held low while reset is asserted so nothing looks accepted.
    assign req_ready      = (state_q == ST_IDLE) && !rst;
    assign hash_req       = (state_q == ST_HREQ);
    assign hash_prefix_in = prefix_q;
    assign hash_len_in    = len_q;
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_hit        = hit_q;
    assign rsp_reject     = reject_q;
    assign rsp_faces      = rfaces_q;

`ifdef FIB_STATS_EN
    logic        rsp_fire;
    logic [15:0] hits_q, hits_d;
    logic [15:0] misses_q, misses_d;
    logic [15:0] rejects_q, rejects_d;

    assign rsp_fire = rsp_valid && rsp_ready;

    always_comb begin
        hits_d    = hits_q;
        misses_d  = misses_q;
        rejects_d = rejects_q;
        if (rsp_fire) begin
            if (reject_q) begin
                if (rejects_q != 16'hFFFF) rejects_d = rejects_q + 16'd1;
            end else if (op_q == OP_LOOKUP) begin
                if (hit_q) begin
                    if (hits_q != 16'hFFFF) hits_d = hits_q + 16'd1;
                end else begin
                    if (misses_q != 16'hFFFF) misses_d = misses_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q    <= '0;
            misses_q  <= '0;
            rejects_q <= '0;
        end else begin
            hits_q    <= hits_d;
            misses_q  <= misses_d;
            rejects_q <= rejects_d;
        end
    end

    assign stat_hits    = hits_q;
    assign stat_misses  = misses_q;
    assign stat_rejects = rejects_q;
`endif

endmodule

// File: doc/fib_hash_table.md
Name: fib_hash_table

Overview:
- Parametrised next-generation FIB for the NDN router datapath.
- Holds DEPTH hash-indexed entries. Each entry is a name prefix plus a FACES-wide next-hop face bitmap.
- Serves lookup, insert and delete requests over one valid/ready request channel from PIT/control. Bucket indices come from the external hash unit over a req/valid handshake.
- Returns hit/miss plus face mask, or insert/delete status, on a valid/ready response channel.

Parameters:
- PREFIX_W, 64, prefix width in bits.
- LEN_W, 7, prefix-length field width; must satisfy 2**LEN_W > PREFIX_W.
- DEPTH, 1024, number of entries; power of two.
- IDX_W, 10, log2(DEPTH); hash index width.
- FACES, 8, number of router faces, i.e. bitmap width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  2  00 lookup, 01 insert, 10 delete, 11 reserved.
- req_prefix  in  PREFIX_W  name prefix, MSB-aligned.
- req_len  in  LEN_W  valid prefix bits counted from MSB, 0..PREFIX_W.
- req_faces  in  FACES  face bitmap; used by insert only.
- hash_req  out  1  one-cycle pulse requesting a hash.
- hash_prefix_in  out  PREFIX_W  masked prefix for the hash unit.
- hash_len_in  out  LEN_W  length for the hash unit.
- hash_valid  in  1  hash result valid.
- hash  in  IDX_W  bucket index.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts the response.
- rsp_hit  out  1  lookup matched, or insert/delete succeeded.
- rsp_reject  out  1  insert collision, delete miss, bad length, or reserved op.
- rsp_faces  out  FACES  face bitmap on a lookup hit, else 0.

Behaviour:
- Reset values:
  - All outputs 0.
  - All entry valid bits cleared in the reset cycle.
  - FSM returns to IDLE, including mid-operation; the outstanding request is dropped with no response.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch op, len, faces and masked prefix (bits below len zeroed).
    - If req_len > PREFIX_W or op==11, go to RESP with rsp_reject=1 and no hash request.
    - Otherwise go to HREQ.
  - HREQ: hash_req=1 for exactly one cycle, then go to HWAIT.
  - HWAIT: wait for hash_valid; capture hash, go to ACCESS. hash_valid outside HWAIT is ignored.
  - ACCESS: read entry[idx]. match = valid && stored_len==len && stored_prefix==masked prefix.
    - lookup: hit=match; faces = match ? stored_faces : 0.
    - insert:
      - Invalid entry or match: write valid=1, prefix, len, faces (overwrite), hit=1.
      - Otherwise: collision, no write, reject=1.
      - req_faces==0 is treated as delete.
    - delete: match clears valid, hit=1; no match gives reject=1.
  - RESP: rsp_valid=1 with stable fields; on rsp_ready go to IDLE and drop rsp_valid.
- hash_prefix_in and hash_len_in hold the latched values from HREQ through HWAIT.
- Latency: lookup response appears 3 cycles after the hash_valid cycle plus hash latency. Concretely, with hash_valid in the cycle after HREQ, rsp_valid rises 4 cycles after request acceptance.
- len==0 is a legal default route: prefix masked to all-zero.
- One request in flight at a time; no pipelining.
- Writes and reads to the same index never overlap.

Optional Feature:
- FIB_STATS_EN defined:
  - Adds outputs stat_hits, stat_misses and stat_rejects, each 16 bits.
  - stat_hits and stat_misses count lookups; stat_rejects counts rejects of any op.
  - Counters increment on the RESP handshake cycle and saturate at 16'hFFFF.
  - All counters clear on rst.
- FIB_STATS_EN undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fib_pkg holds:
  - op encoding constants OP_LOOKUP, OP_INSERT, OP_DELETE;
  - the FSM state enum;
  - the entry struct {valid, prefix, len, faces};
  - a prefix-mask function of (prefix, len).
- One sub-module, fib_entry_ram: DEPTH x entry register array with synchronous write and combinational read, plus a clear-all input driven by rst.

Test Plan:
- Reset, then lookup 64'hA5A5_0000_0000_0000 with len 16 and hash 10'h012 -> rsp_hit=0, rsp_reject=0, rsp_faces=0.
- Insert the same prefix/len with faces 8'h05 and hash 10'h012 -> rsp_hit=1. Then lookup 64'hA5A5_FFFF_0000_0000 with len 16 -> hit, rsp_faces=8'h05, because the masked compare ignores the low bits.
- Insert 64'h1234_0000_0000_0000 with len 16 and hash 10'h012 -> rsp_reject=1. Re-lookup of the A5A5 prefix still returns faces 8'h05.
- Delete A5A5/len 16 -> hit=1. Lookup A5A5 -> miss. Second delete -> reject=1.
- Request with req_len=65 -> rsp_reject=1 and hash_req never asserted. Hold rsp_ready=0 for 5 cycles -> rsp_valid and the response fields stay stable and req_ready=0.
- Assert rst during HWAIT, then drive hash_valid -> no response. Lookup of a previously inserted prefix -> miss.
